// File: rtl/des_perm_pipe.sv
// Elastic valid/ready pipeline that applies the DES final permutation (with half-swap)
// or the initial permutation to each word, carrying a sideband tag and the mode alongside.
module des_perm_pipe #(
    parameter int DEPTH = 2,
    parameter int TAG_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_mode,
    input  logic [32:1]    in_left,
    input  logic [32:1]    in_right,
    input  logic [TAG_W:1] in_tag,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [64:1]    out_data,
    output logic [TAG_W:1] out_tag,
    output logic           out_mode,
    output logic [2:0]     occupancy
);

    // FP source bit for output bit i; IP scatters through the same map in reverse.
    function automatic logic [6:0] src_bit(input int i);
        int r;
        int c;
        int base;
        r = (i - 1) / 8;
        c = (i - 1) % 8;
        case (c)
            0:       base = 40;
            1:       base = 8;
            2:       base = 48;
            3:       base = 16;
            4:       base = 56;
            5:       base = 24;
            6:       base = 64;
            default: base = 32;
        endcase
        return 7'(base - r);
    endfunction

    function automatic logic [64:1] perm_fp(input logic [64:1] w);
        logic [64:1] o;
        o = '0;
        for (int i = 1; i <= 64; i++) begin
            o[7'(i)] = w[src_bit(i)];
        end
        return o;
    endfunction

    function automatic logic [64:1] perm_ip(input logic [64:1] w);
        logic [64:1] o;
        o = '0;
        for (int i = 1; i <= 64; i++) begin
            o[src_bit(i)] = w[7'(i)];
        end
        return o;
    endfunction

    logic [64:1]    word_in;
    logic [64:1]    perm_in;

    logic [64:1]    data_q [DEPTH];
    logic [TAG_W:1] tag_q  [DEPTH];
    logic [DEPTH-1:0] mode_q;
    logic [DEPTH-1:0] v_q;

    logic [64:1]    data_up [DEPTH];
    logic [TAG_W:1] tag_up  [DEPTH];
    logic [DEPTH-1:0] mode_up;
    logic [DEPTH-1:0] v_up;
    logic [DEPTH-1:0] adv;

    // FP mode swaps the halves so that left lands in the low 32 bits before permuting.
    always_comb begin
        word_in = in_mode ? {in_left, in_right} : {in_right, in_left};
        perm_in = in_mode ? perm_ip(word_in) : perm_fp(word_in);
    end

    always_comb begin
        data_up[0] = perm_in;
        tag_up[0]  = in_tag;
        mode_up[0] = in_mode;
        v_up[0]    = in_valid;
        for (int k = 1; k < DEPTH; k++) begin
            data_up[k] = data_q[k-1];
            tag_up[k]  = tag_q[k-1];
            mode_up[k] = mode_q[k-1];
            v_up[k]    = v_q[k-1];
        end
    end

    // A stage may advance when it is empty or its successor advances, so bubbles collapse.
    always_comb begin
        logic a;
        adv = '0;
        a   = !v_q[DEPTH-1] | out_ready;
        adv[DEPTH-1] = a;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            a      = !v_q[k] | a;
            adv[k] = a;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q    <= '0;
            mode_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                data_q[k] <= '0;
                tag_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (adv[k]) begin
                    v_q[k] <= v_up[k];
                    if (v_up[k]) begin
                        data_q[k] <= data_up[k];
                        tag_q[k]  <= tag_up[k];
                        mode_q[k] <= mode_up[k];
                    end
                end
            end
        end
    end

    always_comb begin
        occupancy = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occupancy = occupancy + {2'b00, v_q[k]};
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = v_q[DEPTH-1];
    assign out_data  = data_q[DEPTH-1];
    assign out_tag   = tag_q[DEPTH-1];
    assign out_mode  = mode_q[DEPTH-1];

endmodule
